// File: rtl/alu_dp_pkg.sv
// Shared definitions for the registered ARM data-processing ALU:
// opcode encodings, NZCV bit positions, controller states and opcode class helpers.
package alu_dp_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Logical ops take C from the shifter and leave V alone.
  function automatic logic op_is_logical(input logic [3:0] op);
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: op_is_logical = 1'b1;
      default:                        op_is_logical = 1'b0;
    endcase
  endfunction

  // Compare/test ops only produce flags; writeback is suppressed.
  function automatic logic op_writes_result(input logic [3:0] op);
    case (op)
      OP_TST, OP_TEQ, OP_CMP, OP_CMN: op_writes_result = 1'b0;
      default:                        op_writes_result = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier. One partial product is folded in per cycle over
// WIDTH cycles; o_prod is the accumulator value that the current step will produce,
// so the final product is available combinationally in the cycle where o_done is high.
module alu_mul_iter
  import alu_dp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_accumulate,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_acc_next;

  // Only the low WIDTH product bits are kept, so the multiplicand can shift out the top.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_prod     = w_acc_next;
  assign o_done     = (r_cnt == CW'(1));

  // Load operands on start, then step until the down-counter reaches zero and park.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_cnt    <= CW'(WIDTH);
      r_acc    <= i_accumulate ? i_c : '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (r_cnt != '0) begin
      r_cnt    <= r_cnt - CW'(1);
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_dp_pipe.sv
// Registered ARM data-processing ALU with NZCV flag register and optional iterative
// multiplier. Single output register with valid/ready on both sides.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | accepting requests; ALU ops complete in one cycle
// ST_MUL  | multiplier stepping; input stalled until the product loads
module alu_dp_pipe
  import alu_dp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             set_flags,
  input  logic             is_mul,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] operand_c,
  input  logic             shifter_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             write_result,
  output logic [3:0]       flags_nzcv,
  output logic             busy
);

  state_t           r_state;
  logic             r_out_valid;
  logic             r_write_result;
  logic             r_mul_set_flags;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic             w_accept;
  logic             w_mul_req;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;
  logic             w_is_logical;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_logic_res;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_v;
  logic [3:0]       w_alu_flags;
  logic [3:0]       w_mul_flags;

  assign in_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_mul_req = (MUL_EN != 0) && is_mul;

  // Map every arithmetic op onto x + y + cin; subtraction uses ~operand so C is NOT borrow.
  always_comb begin
    w_x         = operand_a;
    w_y         = operand_b;
    w_cin       = 1'b0;
    w_logic_res = '0;
    case (opcode)
      OP_SUB, OP_CMP: begin w_y = ~operand_b; w_cin = 1'b1; end
      OP_RSB:         begin w_x = operand_b; w_y = ~operand_a; w_cin = 1'b1; end
      OP_ADD, OP_CMN: w_cin = 1'b0;
      OP_ADC:         w_cin = r_flags[FLAG_C];
      OP_SBC:         begin w_y = ~operand_b; w_cin = r_flags[FLAG_C]; end
      OP_RSC:         begin w_x = operand_b; w_y = ~operand_a; w_cin = r_flags[FLAG_C]; end
      OP_AND, OP_TST: w_logic_res = operand_a & operand_b;
      OP_EOR, OP_TEQ: w_logic_res = operand_a ^ operand_b;
      OP_ORR:         w_logic_res = operand_a | operand_b;
      OP_MOV:         w_logic_res = operand_b;
      OP_BIC:         w_logic_res = operand_a & ~operand_b;
      OP_MVN:         w_logic_res = ~operand_b;
      default:        w_logic_res = '0;
    endcase
  end

  assign w_sum        = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  assign w_is_logical = op_is_logical(opcode);
  assign w_alu_res    = w_is_logical ? w_logic_res : w_sum[WIDTH-1:0];
  assign w_alu_v      = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

  // Candidate flags for an ALU op; V is carried through unchanged for logical ops.
  always_comb begin
    w_alu_flags         = r_flags;
    w_alu_flags[FLAG_N] = w_alu_res[WIDTH-1];
    w_alu_flags[FLAG_Z] = (w_alu_res == '0);
    if (w_is_logical) begin
      w_alu_flags[FLAG_C] = shifter_carry;
    end else begin
      w_alu_flags[FLAG_C] = w_sum[WIDTH];
      w_alu_flags[FLAG_V] = w_alu_v;
    end
  end

  // Multiply only touches N and Z.
  always_comb begin
    w_mul_flags         = r_flags;
    w_mul_flags[FLAG_N] = w_mul_prod[WIDTH-1];
    w_mul_flags[FLAG_Z] = (w_mul_prod == '0);
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(
        .WIDTH(WIDTH)
      ) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_accept && w_mul_req),
        .i_accumulate (accumulate),
        .i_a          (operand_a),
        .i_b          (operand_b),
        .i_c          (operand_c),
        .o_done       (w_mul_done),
        .o_prod       (w_mul_prod)
      );
    end else begin : g_no_mul
      assign w_mul_done = 1'b0;
      assign w_mul_prod = '0;
    end
  endgenerate

  // Controller, output register and flag register; flags load on the same edge as result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_out_valid     <= 1'b0;
      r_write_result  <= 1'b0;
      r_mul_set_flags <= 1'b0;
      r_result        <= '0;
      r_flags         <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_mul_req) begin
              r_state         <= ST_MUL;
              r_out_valid     <= 1'b0;
              r_mul_set_flags <= set_flags;
            end else begin
              r_result       <= w_alu_res;
              r_write_result <= op_writes_result(opcode);
              r_out_valid    <= 1'b1;
              if (set_flags) r_flags <= w_alu_flags;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_state        <= ST_IDLE;
            r_result       <= w_mul_prod;
            r_write_result <= 1'b1;
            r_out_valid    <= 1'b1;
            if (r_mul_set_flags) r_flags <= w_mul_flags;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign result       = r_result;
  assign write_result = r_write_result;
  assign flags_nzcv   = r_flags;
  assign busy         = (r_state == ST_MUL);

endmodule

// File: tb/tb_alu_dp_pipe.sv
module tb_alu_dp_pipe;
  import alu_dp_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [3:0]    opcode;
  logic          set_flags, is_mul, accumulate;
  logic [W-1:0]  operand_a, operand_b, operand_c;
  logic          shifter_carry;
  logic          out_valid, out_ready;
  logic [W-1:0]  result;
  logic          write_result;
  logic [3:0]    flags_nzcv;
  logic          busy;

  int checks = 0;
  int failures = 0;

  alu_dp_pipe #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .set_flags(set_flags), .is_mul(is_mul), .accumulate(accumulate),
    .operand_a(operand_a), .operand_b(operand_b), .operand_c(operand_c),
    .shifter_carry(shifter_carry), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .write_result(write_result), .flags_nzcv(flags_nzcv), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic over the architectural definitions.
  function automatic void ref_model(
    input logic [3:0] op, input logic s, input logic mul, input logic acc, input logic sh,
    input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [3:0] fin,
    output logic [31:0] res, output logic wr, output logic [3:0] fout);
    longint ua, ub, sa, sb, sr, u, bor;
    logic cf, vf, arith;
    logic [63:0] p;
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    sa = longint'(signed'(a)); sb = longint'(signed'(b));
    cf = fin[1]; vf = fin[0]; arith = 1'b1; u = 0; sr = 0;
    res = '0; wr = 1'b1; fout = fin;
    bor = fin[1] ? 0 : 1;
    if (mul) begin
      p = {32'd0, a} * {32'd0, b} + (acc ? {32'd0, c} : 64'd0);
      res = p[31:0];
      if (s) begin fout[3] = res[31]; fout[2] = (res == 0); end
      return;
    end
    case (op)
      OP_AND, OP_TST: begin res = a & b; arith = 1'b0; end
      OP_EOR, OP_TEQ: begin res = a ^ b; arith = 1'b0; end
      OP_ORR:         begin res = a | b; arith = 1'b0; end
      OP_MOV:         begin res = b; arith = 1'b0; end
      OP_BIC:         begin res = a & ~b; arith = 1'b0; end
      OP_MVN:         begin res = ~b; arith = 1'b0; end
      OP_ADD, OP_CMN: begin u = ua + ub; sr = sa + sb; cf = u[32]; end
      OP_ADC:         begin u = ua + ub + (fin[1] ? 1 : 0); sr = sa + sb + (fin[1] ? 1 : 0); cf = u[32]; end
      OP_SUB, OP_CMP: begin u = ua - ub; sr = sa - sb; cf = (ua >= ub); end
      OP_RSB:         begin u = ub - ua; sr = sb - sa; cf = (ub >= ua); end
      OP_SBC:         begin u = ua - ub - bor; sr = sa - sb - bor; cf = (ua >= ub + bor); end
      default:        begin u = ub - ua - bor; sr = sb - sa - bor; cf = (ub >= ua + bor); end
    endcase
    if (arith) begin
      res = u[31:0];
      vf = (sr > SMAX) || (sr < SMIN);
    end else begin
      cf = sh;
    end
    wr = !(op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
    if (s) fout = {res[31], (res == 0), cf, vf};
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic        sh;
    logic [31:0] res;
    logic        wr;
    logic [3:0]  nzcv;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        wr;
    logic [3:0]  nzcv;
  } exp_t;

  vec_t tbl[20];
  exp_t sb_q[$];

  task automatic drive(input logic v, input logic [3:0] op, input logic s, input logic m,
                       input logic acc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic sh);
    in_valid = v; opcode = op; set_flags = s; is_mul = m; accumulate = acc;
    operand_a = a; operand_b = b; operand_c = c; shifter_carry = sh;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: pick_operand = 32'h0;
      1: pick_operand = 32'h1;
      2: pick_operand = 32'hFFFF_FFFF;
      3: pick_operand = 32'h8000_0000;
      4: pick_operand = 32'h7FFF_FFFF;
      default: pick_operand = $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  model_flags;
    logic [31:0] m_res;
    logic        m_wr;
    logic [3:0]  m_fl;
    exp_t        e;
    int          guard;

    tbl[0]  = '{OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0000_0000, 1'b1, 4'b0110};
    tbl[1]  = '{OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 1'b1, 4'b1001};
    tbl[2]  = '{OP_CMP, 1'b1, 32'h3,         32'h5,         1'b0, 32'hFFFF_FFFE, 1'b0, 4'b1000};
    tbl[3]  = '{OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0000_0000, 1'b1, 4'b0110};
    tbl[4]  = '{OP_ADC, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_0001, 1'b1, 4'b0110};
    tbl[5]  = '{OP_SBC, 1'b1, 32'h5,         32'h3,         1'b0, 32'h0000_0002, 1'b1, 4'b0010};
    tbl[6]  = '{OP_RSB, 1'b1, 32'h1,         32'h0,         1'b0, 32'hFFFF_FFFF, 1'b1, 4'b1000};
    tbl[7]  = '{OP_SBC, 1'b1, 32'h5,         32'h3,         1'b0, 32'h0000_0001, 1'b1, 4'b0010};
    tbl[8]  = '{OP_AND, 1'b1, 32'hF0F0,      32'h0FF0,      1'b1, 32'h0000_00F0, 1'b1, 4'b0010};
    tbl[9]  = '{OP_MVN, 1'b1, 32'h0,         32'h0,         1'b0, 32'hFFFF_FFFF, 1'b1, 4'b1000};
    tbl[10] = '{OP_TEQ, 1'b1, 32'h5,         32'h5,         1'b1, 32'h0000_0000, 1'b0, 4'b0110};
    tbl[11] = '{OP_ADD, 1'b1, 32'h8000_0000, 32'h8000_0001, 1'b0, 32'h0000_0001, 1'b1, 4'b0011};
    tbl[12] = '{OP_ORR, 1'b0, 32'h1,         32'h2,         1'b0, 32'h0000_0003, 1'b1, 4'b0011};
    tbl[13] = '{OP_RSC, 1'b1, 32'h0,         32'h0,         1'b0, 32'h0000_0000, 1'b1, 4'b0110};
    tbl[14] = '{OP_CMN, 1'b1, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0000_0000, 1'b0, 4'b0110};
    tbl[15] = '{OP_EOR, 1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 32'hF0F0_0F0F, 1'b1, 4'b1000};
    tbl[16] = '{OP_BIC, 1'b1, 32'hFF,        32'h0F,        1'b1, 32'h0000_00F0, 1'b1, 4'b0010};
    tbl[17] = '{OP_MOV, 1'b1, 32'h0,         32'h0,         1'b0, 32'h0000_0000, 1'b1, 4'b0100};
    tbl[18] = '{OP_TST, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 4'b1010};
    tbl[19] = '{OP_SUB, 1'b1, 32'h8000_0000, 32'h1,         1'b0, 32'h7FFF_FFFF, 1'b1, 4'b0011};

    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_write_result", 64'(write_result), 64'd0);
    chk("rst_flags", 64'(flags_nzcv), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back ALU vectors, one accept per cycle.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].s, 1'b0, 1'b0, tbl[i].a, tbl[i].b, 32'h0, tbl[i].sh);
      #1 chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_result", i), 64'(result), 64'(tbl[i].res));
      chk($sformatf("vec%0d_write_result", i), 64'(write_result), 64'(tbl[i].wr));
      chk($sformatf("vec%0d_flags", i), 64'(flags_nzcv), 64'(tbl[i].nzcv));
    end

    // MLA with prior NZCV=0011: product latency WIDTH, C/V preserved.
    drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0001, 32'h5, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("mla_busy_start", 64'({busy, in_ready, out_valid}), 64'b100);
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mla_wait%0d", i), 64'({busy, in_ready, out_valid}), 64'b100);
    end
    @(posedge clk); #1;
    chk("mla_out_valid", 64'(out_valid), 64'd1);
    chk("mla_busy_done", 64'(busy), 64'd0);
    chk("mla_result", 64'(result), 64'h0001_0005);
    chk("mla_flags", 64'(flags_nzcv), 64'b0011);

    // Backpressure on an AND result, then release with the next op waiting.
    drive(1'b1, OP_AND, 1'b1, 1'b0, 1'b0, 32'h0F, 32'hFF, 32'h0, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 32'h1, 32'h1, 32'h0, 1'b0);
    chk("bp_and_result", 64'(result), 64'h0F);
    chk("bp_and_flags", 64'(flags_nzcv), 64'b0001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i),
          64'({out_valid, in_ready, write_result, flags_nzcv, result}),
          64'({1'b1, 1'b0, 1'b1, 4'b0001, 32'h0F}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("bp_release_result", 64'({out_valid, result}), 64'({1'b1, 32'h2}));
    chk("bp_release_flags", 64'(flags_nzcv), 64'b0001);

    // Reset in the middle of a multiply, then an ADD on the first edge after release.
    drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 32'h3, 32'h4, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_state", 64'({out_valid, busy, flags_nzcv}), 64'd0);
    drive(1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 32'h2, 32'h3, 32'h0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("post_rst_add", 64'({out_valid, result, flags_nzcv}), 64'({1'b1, 32'h5, 4'b0000}));
    @(posedge clk); #1;
    chk("post_rst_retire", 64'(out_valid), 64'd0);

    // Randomized traffic against the reference model, scored at the output handshake.
    model_flags = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom),
            $urandom_range(0, 7) == 0, 1'($urandom),
            pick_operand(), pick_operand(), pick_operand(), 1'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("rnd_unexpected_output", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rnd_result", 64'({write_result, flags_nzcv, result}), 64'({e.wr, e.nzcv, e.res}));
        end
      end
      if (in_valid && in_ready) begin
        ref_model(opcode, set_flags, is_mul, accumulate, shifter_carry,
                  operand_a, operand_b, operand_c, model_flags, m_res, m_wr, m_fl);
        model_flags = m_fl;
        sb_q.push_back('{m_res, m_wr, m_fl});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      #1;
      if (out_valid) begin
        e = sb_q.pop_front();
        chk("drain_result", 64'({write_result, flags_nzcv, result}), 64'({e.wr, e.nzcv, e.res}));
      end
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
